// File: rtl/wb_serial_adder_if.sv
// Wishbone classic bus bundle for wb_serial_adder.
// The master drives the request side; the slave returns data, ack and err.
interface wb_serial_adder_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic                  we_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic                  ack_o;
  logic                  err_o;

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_serial_adder.sv
// Wishbone slave with two operand registers, a control/status register and a
// result register. Add/subtract is done one GRANULE-bit slice per clock with a
// registered carry between slices.
module wb_serial_adder #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_serial_adder_if.slave   bus,
  output logic               irq_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int CNT_W     = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;
  // Lane that holds the DONE bit (bit 9) of CTRL/STAT.
  localparam int DONE_LANE = 9 / GRANULE;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] op_a_reg, op_b_reg, result_reg;
  logic [DATA_WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  cin_reg;
  logic                  sub_reg, irq_en_reg, done_reg, carry_reg, ovf_reg;

  logic                  req, rd, wr, wr_err, wr_ok, busy, adr_hi;
  logic                  ctrl_lo_wr, start_go, done_clr, sub_new, last;
  logic [1:0]            word;
  logic [DATA_WIDTH-1:0] lane_mask, rd_data, ctrl_rd;
  logic [GRANULE-1:0]    a_sl, b_sl;
  logic [GRANULE:0]      sum_ext;
  logic                  msb_cin;

  // A new request is only seen once the previous termination has been given.
  assign req  = bus.cyc_i & bus.stb_i & ~bus.ack_o & ~bus.err_o;
  assign rd   = req & ~bus.we_i;
  assign wr   = req & bus.we_i;
  assign word = bus.adr_i[1:0];
  assign busy = (state_reg == RUN);

  generate
    if (ADDR_WIDTH > 2) begin : g_adr_hi
      assign adr_hi = |bus.adr_i[ADDR_WIDTH-1:2];
    end else begin : g_adr_lo
      assign adr_hi = 1'b0;
    end
  endgenerate

  // Expand byte selects into a per-bit write mask.
  generate
    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
      assign lane_mask[gi*GRANULE +: GRANULE] = {GRANULE{bus.sel_i[gi]}};
    end
  endgenerate

  // Lane 0 of CTRL carries START and SUB, so any lane-0 CTRL write while busy
  // is rejected as a whole; the register is left untouched.
  assign wr_err = wr & (adr_hi | (word == 2'd3) |
                  (busy & ((word == 2'd0) | (word == 2'd1) |
                           ((word == 2'd2) & bus.sel_i[0]))));
  assign wr_ok      = wr & ~wr_err;
  assign ctrl_lo_wr = wr_ok & ~adr_hi & (word == 2'd2) & bus.sel_i[0];
  assign start_go   = ctrl_lo_wr & bus.dat_i[0];
  assign sub_new    = ctrl_lo_wr ? bus.dat_i[1] : sub_reg;
  assign done_clr   = wr_ok & ~adr_hi & (word == 2'd2) &
                      bus.sel_i[DONE_LANE] & bus.dat_i[9];

  // One adder slice; operands are shifted down so the active slice is always the LSBs.
  assign a_sl    = a_sh_reg[GRANULE-1:0];
  assign b_sl    = b_sh_reg[GRANULE-1:0];
  assign sum_ext = {1'b0, a_sl} + {1'b0, b_sl} + {{GRANULE{1'b0}}, cin_reg};
  assign msb_cin = a_sl[GRANULE-1] ^ b_sl[GRANULE-1] ^ sum_ext[GRANULE-1];
  assign last    = (cnt_reg == CNT_W'(SEL_WIDTH - 1));

  assign irq_o = done_reg & irq_en_reg;

  // Status word and read-data mux.
  always_comb begin
    ctrl_rd     = '0;
    ctrl_rd[1]  = sub_reg;
    ctrl_rd[2]  = irq_en_reg;
    ctrl_rd[8]  = busy;
    ctrl_rd[9]  = done_reg;
    ctrl_rd[10] = carry_reg;
    ctrl_rd[11] = ovf_reg;
    rd_data     = '0;
    if (!adr_hi) begin
      case (word)
        2'd0:    rd_data = op_a_reg;
        2'd1:    rd_data = op_b_reg;
        2'd2:    rd_data = ctrl_rd;
        default: rd_data = result_reg;
      endcase
    end
  end

  // FSM next-state: IDLE until START, RUN for SEL_WIDTH slices.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_go) state_next = RUN;
      RUN:     if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Bus termination, register writes and slice datapath.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.ack_o  <= 1'b0;
      bus.err_o  <= 1'b0;
      bus.dat_o  <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      cnt_reg    <= '0;
      cin_reg    <= 1'b0;
      sub_reg    <= 1'b0;
      irq_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      bus.ack_o <= rd | wr_ok;
      bus.err_o <= wr_err;
      bus.dat_o <= rd ? rd_data : '0;

      if (wr_ok && !adr_hi && word == 2'd0)
        op_a_reg <= (op_a_reg & ~lane_mask) | (bus.dat_i & lane_mask);
      if (wr_ok && !adr_hi && word == 2'd1)
        op_b_reg <= (op_b_reg & ~lane_mask) | (bus.dat_i & lane_mask);
      if (ctrl_lo_wr) begin
        sub_reg    <= bus.dat_i[1];
        irq_en_reg <= bus.dat_i[2];
      end

      if (start_go) begin
        a_sh_reg <= op_a_reg;
        b_sh_reg <= sub_new ? ~op_b_reg : op_b_reg;
        cin_reg  <= sub_new;
        cnt_reg  <= '0;
      end else if (busy) begin
        result_reg[cnt_reg*GRANULE +: GRANULE] <= sum_ext[GRANULE-1:0];
        a_sh_reg <= a_sh_reg >> GRANULE;
        b_sh_reg <= b_sh_reg >> GRANULE;
        cin_reg  <= sum_ext[GRANULE];
        cnt_reg  <= cnt_reg + 1'b1;
        if (last) begin
          carry_reg <= sum_ext[GRANULE];
          ovf_reg   <= msb_cin ^ sum_ext[GRANULE];
        end
      end

      // Completion has priority over a same-cycle clear.
      if (busy && last)               done_reg <= 1'b1;
      else if (start_go || done_clr)  done_reg <= 1'b0;
    end
  end
endmodule
